// File: rtl/game_round_controller_pkg.sv
// Shared game definitions: FSM state and joystick direction encodings, default round parameters.
// Pure declarations; no timing or flow control of its own.
package game_round_controller_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READY = 3'd1,
    S_PLAY  = 3'd2,
    S_DYING = 3'd3,
    S_OVER  = 3'd4,
    S_WON   = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    DIR_RIGHT = 2'd0,
    DIR_LEFT  = 2'd1,
    DIR_UP    = 2'd2,
    DIR_DOWN  = 2'd3
  } dir_t;

  localparam int DEF_LIVES_INIT  = 3;
  localparam int DEF_READY_TICKS = 60;
  localparam int DEF_DEATH_TICKS = 120;
  localparam int DEF_FOOD_TOTAL  = 240;
  localparam int DEF_FOOD_POINTS = 10;

  localparam int FOOD_CNT_W = 16;

endpackage

// File: rtl/game_round_controller_round_timer.sv
// Counts tick pulses; done pulses combinationally with the TERM_TICKS-th tick, then wraps to 0.
// Held at zero while clear is high; no backpressure, every tick is consumed.
module round_timer #(
  parameter int TERM_TICKS = 60
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic tick,
  output logic done
);

  localparam int CW = (TERM_TICKS > 1) ? $clog2(TERM_TICKS) : 1;

  logic [CW-1:0] cnt;
  logic          at_term;

  assign at_term = (cnt == CW'(TERM_TICKS - 1));
  assign done    = tick && !clear && at_term;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= at_term ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/game_round_controller.sv
// Round sequencing FSM with score and lives bookkeeping; all outputs registered, 1 clk latency.
// No backpressure: frame_tick, food_eaten and start events are sampled every cycle.
module game_round_controller
  import game_round_controller_pkg::*;
#(
  parameter int LIVES_INIT  = DEF_LIVES_INIT,
  parameter int READY_TICKS = DEF_READY_TICKS,
  parameter int DEATH_TICKS = DEF_DEATH_TICKS,
  parameter int FOOD_TOTAL  = DEF_FOOD_TOTAL,
  parameter int FOOD_POINTS = DEF_FOOD_POINTS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        start_btn,
  input  logic        pacman_is_dead,
  input  logic        food_eaten,
  output logic        logic_rst,
  output logic        freeze,
  output logic [1:0]  lives,
  output logic [15:0] score,
  output logic [2:0]  game_state
);

  state_t                state;
  logic                  start_q;
  logic                  start_evt;
  logic [FOOD_CNT_W-1:0] food_cnt;
  logic [FOOD_CNT_W-1:0] food_next;
  logic [16:0]           score_sum;
  logic [15:0]           score_sat;
  logic                  ready_done;
  logic                  death_done;

  assign start_evt  = start_btn && !start_q;
  assign food_next  = food_cnt + FOOD_CNT_W'(1);
  assign score_sum  = {1'b0, score} + 17'(FOOD_POINTS);
  assign score_sat  = score_sum[16] ? 16'hFFFF : score_sum[15:0];
  assign game_state = state;

  // Each timer is held clear outside its own state, so every entry starts from zero.
  round_timer #(.TERM_TICKS(READY_TICKS)) u_ready_timer (
    .clk  (clk),
    .rst  (rst),
    .clear(state != S_READY),
    .tick (frame_tick),
    .done (ready_done)
  );

  round_timer #(.TERM_TICKS(DEATH_TICKS)) u_death_timer (
    .clk  (clk),
    .rst  (rst),
    .clear(state != S_DYING),
    .tick (frame_tick),
    .done (death_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      start_q   <= 1'b0;
      logic_rst <= 1'b1;
      freeze    <= 1'b1;
      lives     <= 2'd0;
      score     <= 16'd0;
      food_cnt  <= '0;
    end else begin
      start_q <= start_btn;
      case (state)
        S_IDLE, S_OVER, S_WON: begin
          if (start_evt) begin
            state     <= S_READY;
            lives     <= 2'(LIVES_INIT);
            score     <= 16'd0;
            food_cnt  <= '0;
            logic_rst <= 1'b1;
            freeze    <= 1'b1;
          end
        end
        S_READY: begin
          if (ready_done) begin
            state     <= S_PLAY;
            logic_rst <= 1'b0;
            freeze    <= 1'b0;
          end
        end
        S_PLAY: begin
          if (food_eaten) begin
            score    <= score_sat;
            food_cnt <= food_next;
          end
          // Clearing the level wins over a simultaneous collision.
          if (food_eaten && food_next == FOOD_CNT_W'(FOOD_TOTAL)) begin
            state  <= S_WON;
            freeze <= 1'b1;
          end else if (pacman_is_dead) begin
            state  <= S_DYING;
            freeze <= 1'b1;
          end
        end
        S_DYING: begin
          if (death_done) begin
            lives <= lives - 2'd1;
            if (lives == 2'd1) begin
              state     <= S_OVER;
              logic_rst <= 1'b0;
            end else begin
              state     <= S_READY;
              logic_rst <= 1'b1;
            end
          end
        end
        default: begin
          state     <= S_IDLE;
          logic_rst <= 1'b1;
          freeze    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_round_controller.sv
// Directed bench: main instance with defaults, a 4-pellet level instance, and a saturation instance.
module tb_game_round_controller;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic frame_tick = 1'b0;
  logic start_btn = 1'b0;
  logic food = 1'b0;
  logic dead = 1'b0;
  int   sel = 0;

  logic food_m, food_w, food_s, dead_m, dead_w, dead_s;
  assign food_m = food && (sel == 0);
  assign food_w = food && (sel == 1);
  assign food_s = food && (sel == 2);
  assign dead_m = dead && (sel == 0);
  assign dead_w = dead && (sel == 1);
  assign dead_s = dead && (sel == 2);

  logic        m_lrst, w_lrst, s_lrst, m_frz, w_frz, s_frz;
  logic [1:0]  m_lives, w_lives, s_lives;
  logic [15:0] m_score, w_score, s_score;
  logic [2:0]  m_st, w_st, s_st;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  game_round_controller dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .start_btn(start_btn),
    .pacman_is_dead(dead_m), .food_eaten(food_m), .logic_rst(m_lrst), .freeze(m_frz),
    .lives(m_lives), .score(m_score), .game_state(m_st)
  );

  game_round_controller #(.FOOD_TOTAL(4)) dut_w (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .start_btn(start_btn),
    .pacman_is_dead(dead_w), .food_eaten(food_w), .logic_rst(w_lrst), .freeze(w_frz),
    .lives(w_lives), .score(w_score), .game_state(w_st)
  );

  game_round_controller #(.FOOD_POINTS(13106), .FOOD_TOTAL(8)) dut_s (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .start_btn(start_btn),
    .pacman_is_dead(dead_s), .food_eaten(food_s), .logic_rst(s_lrst), .freeze(s_frz),
    .lives(s_lives), .score(s_score), .game_state(s_st)
  );

  task automatic cycle_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      @(posedge clk);
      #1;
      frame_tick = 1'b0;
    end
  endtask

  task automatic pulse_food(input logic with_dead);
    food = 1'b1;
    dead = with_dead;
    @(posedge clk);
    #1;
    food = 1'b0;
    dead = 1'b0;
  endtask

  task automatic pulse_dead();
    dead = 1'b1;
    @(posedge clk);
    #1;
    dead = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cycle_n(2);
    rst = 1'b0;
    checks++; if (m_st !== 3'd0) $display("FAIL reset_state: got %0d want 0", m_st); else passes++;
    checks++; if ({m_lrst, m_frz} !== 2'b11) $display("FAIL reset_lrst_frz: got %b want 11", {m_lrst, m_frz}); else passes++;
    checks++; if (m_lives !== 2'd0) $display("FAIL reset_lives: got %0d want 0", m_lives); else passes++;
    checks++; if (m_score !== 16'd0) $display("FAIL reset_score: got %0d want 0", m_score); else passes++;
  endtask

  task automatic test_start_ready();
    start_btn = 1'b1;
    cycle_n(1);
    checks++; if (m_st !== 3'd1) $display("FAIL start_ready_state: got %0d want 1", m_st); else passes++;
    checks++; if ({m_lrst, m_frz} !== 2'b11) $display("FAIL start_ready_lrst_frz: got %b want 11", {m_lrst, m_frz}); else passes++;
    checks++; if (m_lives !== 2'd3) $display("FAIL start_ready_lives: got %0d want 3", m_lives); else passes++;
    tick_n(59);
    checks++; if (m_st !== 3'd1) $display("FAIL ready_tick59: got %0d want 1", m_st); else passes++;
    tick_n(1);
    checks++; if (m_st !== 3'd2) $display("FAIL ready_tick60: got %0d want 2", m_st); else passes++;
    checks++; if ({m_lrst, m_frz} !== 2'b00) $display("FAIL play_lrst_frz: got %b want 00", {m_lrst, m_frz}); else passes++;
    checks++; if ({w_st, s_st} !== {3'd2, 3'd2}) $display("FAIL play_others: got %0d,%0d want 2,2", w_st, s_st); else passes++;
  endtask

  task automatic test_food_score();
    sel = 0;
    for (int i = 0; i < 5; i++) pulse_food(1'b0);
    checks++; if (m_score !== 16'd50) $display("FAIL food_score: got %0d want 50", m_score); else passes++;
    checks++; if (m_st !== 3'd2) $display("FAIL food_state: got %0d want 2", m_st); else passes++;
    start_btn = 1'b0;
    cycle_n(1);
    start_btn = 1'b1;
    cycle_n(2);
    start_btn = 1'b0;
    cycle_n(1);
    checks++; if (m_st !== 3'd2) $display("FAIL start_in_play: got %0d want 2", m_st); else passes++;
    checks++; if (m_score !== 16'd50) $display("FAIL start_in_play_score: got %0d want 50", m_score); else passes++;
  endtask

  task automatic test_win_priority();
    sel = 1;
    for (int i = 0; i < 3; i++) pulse_food(1'b0);
    checks++; if ({w_st, w_score} !== {3'd2, 16'd30}) $display("FAIL win_pre: got %0d/%0d want 2/30", w_st, w_score); else passes++;
    pulse_food(1'b1);
    checks++; if (w_st !== 3'd5) $display("FAIL win_state: got %0d want 5", w_st); else passes++;
    checks++; if (w_score !== 16'd40) $display("FAIL win_score: got %0d want 40", w_score); else passes++;
    checks++; if ({w_lives, w_frz} !== {2'd3, 1'b1}) $display("FAIL win_lives_frz: got %0d/%b want 3/1", w_lives, w_frz); else passes++;
    checks++; if ({m_st, m_score} !== {3'd2, 16'd50}) $display("FAIL win_isolation: got %0d/%0d want 2/50", m_st, m_score); else passes++;
    sel = 0;
  endtask

  task automatic test_saturation();
    sel = 2;
    for (int i = 0; i < 5; i++) pulse_food(1'b0);
    checks++; if (s_score !== 16'd65530) $display("FAIL sat_preload: got %0d want 65530", s_score); else passes++;
    pulse_food(1'b0);
    checks++; if (s_score !== 16'd65535) $display("FAIL sat_first: got %0d want 65535", s_score); else passes++;
    pulse_food(1'b0);
    checks++; if (s_score !== 16'd65535) $display("FAIL sat_hold: got %0d want 65535", s_score); else passes++;
    checks++; if (s_st !== 3'd2) $display("FAIL sat_state: got %0d want 2", s_st); else passes++;
    sel = 0;
  endtask

  task automatic test_death_to_over();
    sel = 0;
    pulse_dead();
    checks++; if ({m_st, m_frz, m_lrst} !== {3'd3, 1'b1, 1'b0}) $display("FAIL dying_enter: got %0d/%b/%b want 3/1/0", m_st, m_frz, m_lrst); else passes++;
    tick_n(119);
    checks++; if ({m_st, m_lives} !== {3'd3, 2'd3}) $display("FAIL dying_tick119: got %0d/%0d want 3/3", m_st, m_lives); else passes++;
    tick_n(1);
    checks++; if ({m_st, m_lives, m_lrst} !== {3'd1, 2'd2, 1'b1}) $display("FAIL dying_to_ready: got %0d/%0d/%b want 1/2/1", m_st, m_lives, m_lrst); else passes++;
    tick_n(60);
    pulse_dead();
    tick_n(120);
    checks++; if ({m_st, m_lives} !== {3'd1, 2'd1}) $display("FAIL second_death: got %0d/%0d want 1/1", m_st, m_lives); else passes++;
    tick_n(60);
    pulse_dead();
    tick_n(120);
    checks++; if ({m_st, m_lives} !== {3'd4, 2'd0}) $display("FAIL over_state: got %0d/%0d want 4/0", m_st, m_lives); else passes++;
    checks++; if (m_score !== 16'd50) $display("FAIL over_score: got %0d want 50", m_score); else passes++;
    checks++; if ({m_lrst, m_frz} !== 2'b01) $display("FAIL over_lrst_frz: got %b want 01", {m_lrst, m_frz}); else passes++;
    pulse_food(1'b0);
    pulse_dead();
    checks++; if ({m_st, m_score} !== {3'd4, 16'd50}) $display("FAIL over_ignore: got %0d/%0d want 4/50", m_st, m_score); else passes++;
  endtask

  task automatic test_reset_mid_dying();
    sel = 0;
    start_btn = 1'b1;
    cycle_n(1);
    start_btn = 1'b0;
    checks++; if ({m_st, m_lives, m_score} !== {3'd1, 2'd3, 16'd0}) $display("FAIL restart: got %0d/%0d/%0d want 1/3/0", m_st, m_lives, m_score); else passes++;
    tick_n(60);
    pulse_dead();
    tick_n(50);
    rst = 1'b1;
    cycle_n(1);
    rst = 1'b0;
    checks++; if ({m_st, m_lives, m_score} !== {3'd0, 2'd0, 16'd0}) $display("FAIL mid_rst: got %0d/%0d/%0d want 0/0/0", m_st, m_lives, m_score); else passes++;
    checks++; if ({m_lrst, m_frz} !== 2'b11) $display("FAIL mid_rst_lrst_frz: got %b want 11", {m_lrst, m_frz}); else passes++;
    start_btn = 1'b1;
    cycle_n(1);
    start_btn = 1'b0;
    tick_n(59);
    checks++; if (m_st !== 3'd1) $display("FAIL fresh_ready59: got %0d want 1", m_st); else passes++;
    tick_n(1);
    checks++; if (m_st !== 3'd2) $display("FAIL fresh_ready60: got %0d want 2", m_st); else passes++;
    pulse_dead();
    tick_n(119);
    checks++; if (m_st !== 3'd3) $display("FAIL fresh_dying119: got %0d want 3", m_st); else passes++;
    tick_n(1);
    checks++; if ({m_st, m_lives} !== {3'd1, 2'd2}) $display("FAIL fresh_dying120: got %0d/%0d want 1/2", m_st, m_lives); else passes++;
  endtask

  initial begin
    test_reset();
    test_start_ready();
    test_food_score();
    test_win_priority();
    test_saturation();
    test_death_to_over();
    test_reset_mid_dying();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
